// File: rtl/sample_stream_sequencer_pkg.sv
// Shared regression definitions: sequencer state encoding and default sample geometry.
package sample_stream_sequencer_pkg;

    localparam int unsigned SEQ_DEPTH = 150;
    localparam int unsigned SEQ_DW    = 20;
    localparam int unsigned SEQ_AW    = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        COEF_STREAM = 3'd2,
        COEF_WAIT   = 3'd3,
        ERR_STREAM  = 3'd4,
        ERR_WAIT    = 3'd5,
        DONE        = 3'd6
    } seq_state_t;

endpackage

// File: rtl/sample_ram.sv
// Dual-array (x,y) sample buffer: one write port, one registered read port whose
// output register doubles as the sequencer's outx/outy.
module sample_ram
    import sample_stream_sequencer_pkg::*;
#(
    parameter int unsigned DW    = SEQ_DW,
    parameter int unsigned AW    = SEQ_AW,
    parameter int unsigned DEPTH = SEQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wx,
    input  logic [DW-1:0] wy,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rx,
    output logic [DW-1:0] ry
);

    logic [DW-1:0] mem_x [DEPTH];
    logic [DW-1:0] mem_y [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_x[waddr] <= wx;
            mem_y[waddr] <= wy;
        end
    end

    // Same-address read-during-write forwards the new data (only reachable when DEPTH is 1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx <= '0;
            ry <= '0;
        end else if (re) begin
            if (we && (waddr == raddr)) begin
                rx <= wx;
                ry <= wy;
            end else begin
                rx <= mem_x[raddr];
                ry <= mem_y[raddr];
            end
        end
    end

endmodule

// File: rtl/sample_stream_sequencer.sv
// Captures DEPTH (x,y) samples, then streams them once to the coefficient stage
// and once more to the error-check stage, handshaking with each stage's done flag.
module sample_stream_sequencer
    import sample_stream_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = SEQ_DEPTH,
    parameter int unsigned DW    = SEQ_DW,
    parameter int unsigned AW    = SEQ_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] inx,
    input  logic [DW-1:0] iny,
    input  logic          coef_done,
    input  logic          err_done,
    output logic [DW-1:0] outx,
    output logic [DW-1:0] outy,
    output logic          en_coef,
    output logic          en_err,
    output logic          cout,
    output logic          busy,
    output logic          finishd
);

    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
    localparam logic          SINGLE = (DEPTH == 1);

    seq_state_t    state, state_d;
    logic [AW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, rd_nxt_c, raddr_c;
    logic          we_c, re_c, en_coef_d, en_err_d, cout_d, finishd_d;

    assign rd_nxt_c = rd_ptr + AW'(1);

    // Next state; the read port is driven one cycle ahead so data, enable and cout land together.
    always_comb begin
        state_d   = state;
        wr_ptr_d  = wr_ptr;
        rd_ptr_d  = rd_ptr;
        we_c      = 1'b0;
        re_c      = 1'b0;
        raddr_c   = rd_ptr;
        en_coef_d = 1'b0;
        en_err_d  = 1'b0;
        cout_d    = 1'b0;
        finishd_d = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    we_c = 1'b1;
                    if (wr_ptr == LAST) begin
                        state_d   = COEF_STREAM;
                        rd_ptr_d  = '0;
                        re_c      = 1'b1;
                        raddr_c   = '0;
                        en_coef_d = 1'b1;
                        cout_d    = SINGLE;
                    end else begin
                        wr_ptr_d = wr_ptr + AW'(1);
                    end
                end
            end
            COEF_STREAM: begin
                if (rd_ptr == LAST) begin
                    state_d = COEF_WAIT;
                end else begin
                    rd_ptr_d  = rd_nxt_c;
                    re_c      = 1'b1;
                    raddr_c   = rd_nxt_c;
                    en_coef_d = 1'b1;
                    cout_d    = (rd_nxt_c == LAST);
                end
            end
            COEF_WAIT: begin
                if (coef_done) begin
                    state_d  = ERR_STREAM;
                    rd_ptr_d = '0;
                    re_c     = 1'b1;
                    raddr_c  = '0;
                    en_err_d = 1'b1;
                    cout_d   = SINGLE;
                end
            end
            ERR_STREAM: begin
                if (rd_ptr == LAST) begin
                    state_d = ERR_WAIT;
                end else begin
                    rd_ptr_d = rd_nxt_c;
                    re_c     = 1'b1;
                    raddr_c  = rd_nxt_c;
                    en_err_d = 1'b1;
                    cout_d   = (rd_nxt_c == LAST);
                end
            end
            ERR_WAIT: begin
                if (err_done) begin
                    state_d   = DONE;
                    finishd_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            en_coef <= 1'b0;
            en_err  <= 1'b0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            finishd <= 1'b0;
        end else begin
            state   <= state_d;
            wr_ptr  <= wr_ptr_d;
            rd_ptr  <= rd_ptr_d;
            en_coef <= en_coef_d;
            en_err  <= en_err_d;
            cout    <= cout_d;
            busy    <= (state_d != IDLE);
            finishd <= finishd_d;
        end
    end

    sample_ram #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_c),
        .waddr (wr_ptr),
        .wx    (inx),
        .wy    (iny),
        .re    (re_c),
        .raddr (raddr_c),
        .rx    (outx),
        .ry    (outy)
    );

endmodule
